// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and address-field geometry for the write-back data cache
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  function automatic int offset_w(input int words_per_block);
    return $clog2(words_per_block);
  endfunction
  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(input int word_size, input int words_per_block, input int num_lines);
    return word_size - offset_w(words_per_block) - index_w(num_lines);
  endfunction
  function automatic int block_size(input int word_size, input int words_per_block);
    return word_size * words_per_block;
  endfunction
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/dirty/tag/data storage with combinational read and synchronous word write or line install
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_LINES = 4,
  localparam int OW = offset_w(WORDS_PER_BLOCK),
  localparam int IW = index_w(NUM_LINES),
  localparam int IWS = IW > 0 ? IW : 1,
  localparam int TW = tag_w(WORD_SIZE, WORDS_PER_BLOCK, NUM_LINES),
  localparam int BS = block_size(WORD_SIZE, WORDS_PER_BLOCK)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IWS-1:0]       idx,
  output logic                 valid,
  output logic                 dirty,
  output logic [TW-1:0]        tag,
  output logic [BS-1:0]        block,
  input  logic                 wr_en,
  input  logic [OW-1:0]        wr_off,
  input  logic [WORD_SIZE-1:0] wr_word,
  input  logic                 inst_en,
  input  logic [TW-1:0]        inst_tag,
  input  logic [BS-1:0]        inst_block
);
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0] tags [NUM_LINES];
  logic [BS-1:0] data [NUM_LINES];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag = tags[idx];
  assign block = data[idx];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) dirty_q[idx] <= 1'b1;
  always_ff @(posedge clk)
    if (inst_en) begin
      tags[idx] <= inst_tag;
      data[idx] <= inst_block;
    end else if (wr_en) data[idx][wr_off*WORD_SIZE +: WORD_SIZE] <= wr_word;
endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: parametrised write-back, write-allocate, direct-mapped data cache with statistics counters
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_LINES = 4,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 d_readC,
  input  logic                                 d_writeC,
  input  logic [WORD_SIZE-1:0]                 d_addressC,
  inout  wire  [WORD_SIZE-1:0]                 d_dataC,
  output logic                                 d_readyC,
  output logic                                 stall,
  output logic                                 d_readM,
  output logic                                 d_writeM,
  output logic [WORD_SIZE-1:0]                 d_address,
  inout  wire  [WORD_SIZE*WORDS_PER_BLOCK-1:0] d_data,
  output logic [CNT_WIDTH-1:0]                 access_count,
  output logic [CNT_WIDTH-1:0]                 miss_count,
  output logic [CNT_WIDTH-1:0]                 wb_count
);
  localparam int OW = offset_w(WORDS_PER_BLOCK);
  localparam int IW = index_w(NUM_LINES);
  localparam int IWS = IW > 0 ? IW : 1;
  localparam int TW = tag_w(WORD_SIZE, WORDS_PER_BLOCK, NUM_LINES);
  localparam int BS = block_size(WORD_SIZE, WORDS_PER_BLOCK);
  localparam int LW = $clog2(MEM_LATENCY) + 1;
  state_t state, state_n;
  logic [LW-1:0] lat;
  logic [TW-1:0] m_tag, r_tag, l_tag;
  logic [IWS-1:0] m_idx, r_idx, idx;
  logic [OW-1:0] r_off;
  logic [BS-1:0] l_block;
  logic [WORD_SIZE-1:0] r_word;
  logic l_valid, l_dirty, req, hit, miss, last, wr_en, inst_en;
  function automatic logic [WORD_SIZE-1:0] block_addr(input logic [TW-1:0] t, input logic [IWS-1:0] i);
    return (WORD_SIZE'(t) << (OW + IW)) | (WORD_SIZE'(i) << OW);
  endfunction
  assign r_off = d_addressC[OW-1:0];
  assign r_idx = IW > 0 ? IWS'(d_addressC >> OW) : '0;
  assign r_tag = TW'(d_addressC >> (OW + IW));
  assign idx = state == IDLE ? r_idx : m_idx;
  assign req = d_readC | d_writeC;
  assign hit = l_valid && l_tag == r_tag;
  assign d_readyC = req && state == IDLE && hit;
  assign stall = req && !d_readyC;
  assign miss = req && state == IDLE && !hit;
  assign last = lat == '0;
  assign wr_en = d_readyC && d_writeC;
  assign inst_en = state == REFILL && last;
  assign d_readM = state == REFILL;
  assign d_writeM = state == WRITEBACK;
  assign d_address = d_writeM ? block_addr(l_tag, m_idx) : d_readM ? block_addr(m_tag, m_idx) : '0;
  assign r_word = l_block[r_off*WORD_SIZE +: WORD_SIZE];
  assign d_dataC = (d_readC && !d_writeC && d_readyC) ? r_word : 'z;
  assign d_data = d_writeM ? l_block : 'z;
  always_comb
    state_n = state == IDLE ? (miss ? (l_valid && l_dirty ? WRITEBACK : REFILL) : IDLE)
            : state == WRITEBACK ? (last ? REFILL : WRITEBACK)
            : (last ? IDLE : REFILL);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      lat <= '0;
      m_tag <= '0;
      m_idx <= '0;
      access_count <= '0;
      miss_count <= '0;
      wb_count <= '0;
    end else begin
      state <= state_n;
      lat <= state_n != state ? LW'(MEM_LATENCY - 1) : lat - 1'b1;
      if (miss) begin
        m_tag <= r_tag;
        m_idx <= r_idx;
      end
      if (d_readyC && access_count != '1) access_count <= access_count + 1'b1;
      if (miss && miss_count != '1) miss_count <= miss_count + 1'b1;
      if (d_writeM && last && wb_count != '1) wb_count <= wb_count + 1'b1;
    end
  dcache_line_array #(
    .WORD_SIZE(WORD_SIZE),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
    .NUM_LINES(NUM_LINES)
  ) u_lines (
    .clk(clk),
    .reset_n(reset_n),
    .idx(idx),
    .valid(l_valid),
    .dirty(l_dirty),
    .tag(l_tag),
    .block(l_block),
    .wr_en(wr_en),
    .wr_off(r_off),
    .wr_word(d_dataC),
    .inst_en(inst_en),
    .inst_tag(m_tag),
    .inst_block(d_data)
  );
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: randomized self-checking bench for dcache_wb against a cache-contents reference model
module tb_dcache_wb;
  localparam int L = 4;
  logic clk = 0, reset_n = 1, d_readC = 0, d_writeC = 0;
  logic [15:0] d_addressC = 0, cpu_wdata = 0;
  wire [15:0] d_dataC;
  wire [63:0] d_data;
  logic d_readyC, stall, d_readM, d_writeM;
  logic [15:0] d_address, access_count, miss_count, wb_count;
  logic [63:0] rblk = 0;
  logic [15:0] bmem [65536];
  bit bw [65536];
  logic [15:0] ref_mem [int];
  bit mvalid [4], mdirty [4];
  logic [11:0] mtag [4];
  int checks = 0, errors = 0;
  int e_acc = 0, e_miss = 0, e_wb = 0;
  int lat, nrm, nwm;
  logic [15:0] rd, arm, awm;
  logic [63:0] wblk;
  dcache_wb #(.WORD_SIZE(16), .WORDS_PER_BLOCK(4), .NUM_LINES(4), .MEM_LATENCY(L), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .d_readC(d_readC), .d_writeC(d_writeC), .d_addressC(d_addressC),
    .d_dataC(d_dataC), .d_readyC(d_readyC), .stall(stall), .d_readM(d_readM), .d_writeM(d_writeM),
    .d_address(d_address), .d_data(d_data), .access_count(access_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );
  always #5 clk = ~clk;
  assign d_dataC = d_writeC ? cpu_wdata : 'z;
  assign d_data = d_readM ? rblk : 'z;
  function automatic logic [15:0] mrd(input int k);
    return bw[k] ? bmem[k] : 16'(k);
  endfunction
  function automatic logic [15:0] rref(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 16'(k);
  endfunction
  always @(negedge clk)
    for (int i = 0; i < 4; i++) rblk[i*16 +: 16] <= mrd(int'(d_address) + i);
  always @(posedge clk)
    if (d_writeM)
      for (int i = 0; i < 4; i++) begin
        bmem[int'(d_address) + i] <= d_data[i*16 +: 16];
        bw[int'(d_address) + i] <= 1'b1;
      end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_counts();
    check("access_count", access_count, 16'(e_acc));
    check("miss_count", miss_count, 16'(e_miss));
    check("wb_count", wb_count, 16'(e_wb));
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
    end
    e_acc = 0;
    e_miss = 0;
    e_wb = 0;
  endtask
  // mode 0 read, 1 write, 2 read and write together (behaves as a write)
  task automatic acc(input int mode, input logic [15:0] a, input logic [15:0] wd);
    int idx, elat;
    logic [11:0] tg;
    logic [15:0] wa;
    bit hit, dv;
    idx = int'(a[3:2]);
    tg = a[15:4];
    hit = mvalid[idx] && mtag[idx] == tg;
    dv = !hit && mvalid[idx] && mdirty[idx];
    elat = hit ? 0 : dv ? 2 * L + 1 : L + 1;
    wa = {mtag[idx], a[3:2], 2'b00};
    @(posedge clk);
    #1;
    d_addressC = a;
    d_readC = mode != 1;
    d_writeC = mode != 0;
    cpu_wdata = wd;
    lat = 0; nrm = 0; nwm = 0; arm = 0; awm = 0; wblk = 0; rd = 0;
    forever begin
      @(negedge clk);
      if (d_readM) begin nrm++; arm = d_address; end
      if (d_writeM) begin nwm++; awm = d_address; wblk = d_data; end
      if (d_readyC) begin rd = d_dataC; break; end
      lat++;
      if (lat > 40) break;
    end
    check("latency", lat, elat);
    check("readM_cycles", nrm, hit ? 0 : L);
    check("writeM_cycles", nwm, dv ? L : 0);
    if (!hit) check("refill_addr", arm, {a[15:2], 2'b00});
    if (dv) begin
      check("wb_addr", awm, wa);
      check("wb_block", wblk, {rref(wa + 3), rref(wa + 2), rref(wa + 1), rref(int'(wa))});
    end
    if (mode == 0) check("read_data", rd, rref(int'(a)));
    if (!hit) begin
      e_miss++;
      if (dv) e_wb++;
      mvalid[idx] = 1;
      mdirty[idx] = 0;
      mtag[idx] = tg;
    end
    e_acc++;
    if (mode != 0) begin
      mdirty[idx] = 1;
      ref_mem[int'(a)] = wd;
    end
    @(posedge clk);
    #1;
    d_readC = 0;
    d_writeC = 0;
    check_counts();
  endtask
  initial begin
    #2 reset_n = 0;
    model_reset();
    #10;
    check("rst_readM", d_readM, 0);
    check("rst_writeM", d_writeM, 0);
    check("rst_address", d_address, 0);
    check("rst_stall", stall, 0);
    check("rst_readyC", d_readyC, 0);
    check_counts();
    @(negedge clk) reset_n = 1;
    acc(0, 16'h0012, 0);
    acc(0, 16'h0013, 0);
    acc(1, 16'h0011, 16'hBEEF);
    acc(0, 16'h0051, 0);
    check("wb_word1", wblk[31:16], 16'hBEEF);
    acc(1, 16'h0025, 16'h1234);
    acc(0, 16'h0025, 0);
    check("wma_read", rd, 16'h1234);
    @(posedge clk);
    #1;
    d_addressC = 16'h0012;
    d_readC = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_refill_readM", d_readM, 1);
    check("mid_refill_stall", stall, 1);
    reset_n = 0;
    #1;
    check("abort_readM", d_readM, 0);
    check("abort_address", d_address, 0);
    model_reset();
    check_counts();
    d_readC = 0;
    #1;
    check("abort_stall", stall, 0);
    check("abort_readyC", d_readyC, 0);
    @(negedge clk) reset_n = 1;
    acc(0, 16'h0012, 0);
    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 63));
      a[15] = 1'($urandom_range(0, 1));
      acc(int'($urandom_range(0, 2)), a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
